perceptron_train_engine: RTL and testbench

Parametrised multi-lane training engine for the perceptron branch predictor. Accepts resolved-branch training requests through a valid/ready handshake and filters them against the training threshold. Qualifying requests are queued in a small FIFO. Each queued request is then applied to the weight table as a saturating read-modify-write, LANES weights per group. Sits between the EX-stage branch-result path and the perceptron weight RAM, replacing single-cycle whole-table update logic.

---
 rtl/perceptron_train_engine.sv | 231 +++++++++++++++++++++++
 tb/tb_perceptron_train_engine.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perceptron_train_engine.sv
// Perceptron training engine: threshold filter, request FIFO and grouped saturating RMW of the weight RAM.
// Optional adaptive threshold enabled by defining PERCEPTRON_ADAPTIVE_THETA_EN.
module perceptron_train_engine #(
    parameter  int PERCEPTRON_NUMBER = 64,
    parameter  int HISTORY_SIZE      = 16,
    parameter  int WIDTH             = 8,
    parameter  int LANES             = 4,
    parameter  int FIFO_DEPTH        = 4,
    parameter  int SUM_WIDTH         = 16,
    localparam int NGROUPS           = (HISTORY_SIZE + LANES) / LANES,
    localparam int IDX_W             = $clog2(PERCEPTRON_NUMBER),
    localparam int GRP_W             = $clog2(NGROUPS),
    localparam int ADDR_W            = IDX_W + GRP_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [IDX_W-1:0]            req_idx,
    input  logic [HISTORY_SIZE-1:0]     req_hist,
    input  logic signed [SUM_WIDTH-1:0] req_sum,
    input  logic                        req_outcome,
    output logic                        wt_rd_en,
    output logic [ADDR_W-1:0]           wt_addr,
    input  logic [LANES*WIDTH-1:0]      wt_rd_data,
    output logic                        wt_wr_en,
    output logic [LANES*WIDTH-1:0]      wt_wr_data,
    output logic                        busy,
    output logic                        upd_done,
    output logic [31:0]                 trained_cnt,
    output logic [31:0]                 skipped_cnt
);

    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int ABS_W      = SUM_WIDTH + 1;
    localparam int THETA_INIT = (193 * HISTORY_SIZE + 1400) / 100;
    localparam int TOT        = NGROUPS * LANES;
    localparam logic signed [WIDTH-1:0] W_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] W_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

    function automatic logic signed [WIDTH-1:0] sat_step(input logic signed [WIDTH-1:0] w,
                                                         input logic up);
        if (up)
            return (w == W_MAX) ? w : w + WIDTH'(1);
        return (w == W_MIN) ? w : w - WIDTH'(1);
    endfunction

    state_t                    r_state, w_state_nxt;
    logic                      r_rdy;
    logic [PTR_W:0]            r_wptr, r_rptr;
    logic [IDX_W-1:0]          r_fifo_idx  [FIFO_DEPTH];
    logic [HISTORY_SIZE-1:0]   r_fifo_hist [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]     r_fifo_out;
    logic [IDX_W-1:0]          r_row;
    logic [HISTORY_SIZE-1:0]   r_hist;
    logic                      r_outcome;
    logic [GRP_W-1:0]          r_grp;
    logic                      r_upd_done;
    logic [31:0]               r_trained_cnt, r_skipped_cnt;

    logic                      w_empty, w_full, w_fire, w_push, w_skip, w_pop;
    logic                      w_pred, w_mispred, w_train;
    logic signed [ABS_W-1:0]   w_sum_ext;
    logic [ABS_W-1:0]          w_abs, w_theta;
    logic                      w_rd_en, w_wr_en, w_last;
    logic [TOT-1:0]            w_xvec, w_mask;
    logic [LANES-1:0]          w_xgrp, w_mgrp;
    logic [LANES*WIDTH-1:0]    w_new;

    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                       (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
    assign req_ready = r_rdy && !w_full;
    assign w_fire    = req_valid && req_ready;

    // Confidence filter: |y| is formed one bit wider so the most negative sum cannot overflow.
    assign w_sum_ext = {req_sum[SUM_WIDTH-1], req_sum};
    assign w_abs     = req_sum[SUM_WIDTH-1] ? -w_sum_ext : w_sum_ext;
    assign w_pred    = ~req_sum[SUM_WIDTH-1];
    assign w_mispred = w_pred ^ req_outcome;
    assign w_train   = w_mispred || (w_abs <= w_theta);
    assign w_push    = w_fire && w_train;
    assign w_skip    = w_fire && !w_train;

`ifdef PERCEPTRON_ADAPTIVE_THETA_EN
    localparam int TH_W = $clog2(4 * THETA_INIT);
    localparam logic [TH_W-1:0] TH_MAX = '1;
    logic [TH_W-1:0]  r_theta;
    logic signed [6:0] r_tc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_theta <= TH_W'(THETA_INIT);
            r_tc    <= '0;
        end else if (w_push) begin
            if (w_mispred) begin
                if (r_tc == 7'sd62) begin
                    r_tc <= '0;
                    if (r_theta != TH_MAX)
                        r_theta <= r_theta + 1'b1;
                end else begin
                    r_tc <= r_tc + 7'sd1;
                end
            end else begin
                if (r_tc == -7'sd63) begin
                    r_tc <= '0;
                    if (r_theta > TH_W'(1))
                        r_theta <= r_theta - 1'b1;
                end else begin
                    r_tc <= r_tc - 7'sd1;
                end
            end
        end
    end

    assign w_theta = ABS_W'(r_theta);
`else
    assign w_theta = ABS_W'(THETA_INIT);
`endif

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_idx[r_wptr[PTR_W-1:0]]  <= req_idx;
            r_fifo_hist[r_wptr[PTR_W-1:0]] <= req_hist;
            r_fifo_out[r_wptr[PTR_W-1:0]]  <= req_outcome;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy         <= 1'b0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_trained_cnt <= '0;
            r_skipped_cnt <= '0;
            r_upd_done    <= 1'b0;
        end else begin
            r_rdy      <= 1'b1;
            r_upd_done <= w_last;
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            if (w_skip && (r_skipped_cnt != '1))
                r_skipped_cnt <= r_skipped_cnt + 32'd1;
            if (w_last && (r_trained_cnt != '1))
                r_trained_cnt <= r_trained_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_rd_en     = 1'b0;
        w_wr_en     = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_RD;
                end
            end
            S_RD: begin
                w_rd_en     = 1'b1;
                w_state_nxt = S_WR;
            end
            S_WR: begin
                w_wr_en = 1'b1;
                if (r_grp == GRP_W'(NGROUPS - 1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RD;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row     <= '0;
            r_hist    <= '0;
            r_outcome <= 1'b0;
            r_grp     <= '0;
        end else if (w_pop) begin
            r_row     <= r_fifo_idx[r_rptr[PTR_W-1:0]];
            r_hist    <= r_fifo_hist[r_rptr[PTR_W-1:0]];
            r_outcome <= r_fifo_out[r_rptr[PTR_W-1:0]];
            r_grp     <= '0;
        end else if (w_wr_en && !w_last) begin
            r_grp <= r_grp + 1'b1;
        end
    end

    // Bit j of w_xvec is x_j encoded as 1 => +1; w_mask marks real weights, so padding lanes pass through.
    always_comb begin
        w_xvec                 = '0;
        w_xvec[HISTORY_SIZE:0] = {r_hist, 1'b1};
        w_mask                 = '0;
        w_mask[HISTORY_SIZE:0] = '1;
        w_xgrp                 = w_xvec[int'(r_grp) * LANES +: LANES];
        w_mgrp                 = w_mask[int'(r_grp) * LANES +: LANES];
        w_new                  = wt_rd_data;
        for (int k = 0; k < LANES; k++) begin
            if (w_mgrp[k])
                w_new[k*WIDTH +: WIDTH] = sat_step(wt_rd_data[k*WIDTH +: WIDTH],
                                                   r_outcome == w_xgrp[k]);
        end
    end

    assign wt_rd_en    = w_rd_en;
    assign wt_wr_en    = w_wr_en;
    assign wt_addr     = (w_rd_en || w_wr_en) ? {r_row, r_grp} : '0;
    assign wt_wr_data  = w_wr_en ? w_new : '0;
    assign busy        = (r_state != S_IDLE) || !w_empty;
    assign upd_done    = r_upd_done;
    assign trained_cnt = r_trained_cnt;
    assign skipped_cnt = r_skipped_cnt;

endmodule

// File: tb/tb_perceptron_train_engine.sv
// Self-checking bench for perceptron_train_engine: RAM model plus a per-weight reference model.
module tb_perceptron_train_engine;

    localparam int H      = 16;
    localparam int THETA0 = (193 * H + 1400) / 100;

    logic               clk;
    logic               rst_n;
    logic               req_valid;
    logic               req_ready;
    logic [5:0]         req_idx;
    logic [15:0]        req_hist;
    logic signed [15:0] req_sum;
    logic               req_outcome;
    logic               wt_rd_en;
    logic [8:0]         wt_addr;
    logic [31:0]        wt_rd_data;
    logic               wt_wr_en;
    logic [31:0]        wt_wr_data;
    logic               busy;
    logic               upd_done;
    logic [31:0]        trained_cnt;
    logic [31:0]        skipped_cnt;

    perceptron_train_engine dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_idx(req_idx),
        .req_hist(req_hist), .req_sum(req_sum), .req_outcome(req_outcome),
        .wt_rd_en(wt_rd_en), .wt_addr(wt_addr), .wt_rd_data(wt_rd_data),
        .wt_wr_en(wt_wr_en), .wt_wr_data(wt_wr_data),
        .busy(busy), .upd_done(upd_done),
        .trained_cnt(trained_cnt), .skipped_cnt(skipped_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Weight RAM with one-cycle read latency; the bench preloads it through pre_*.
    logic [31:0] ram [512];
    logic        pre_we;
    logic [8:0]  pre_addr;
    logic [31:0] pre_data;
    int          acc_log[$];
    int          n_done;

    always @(posedge clk) begin
        if (wt_rd_en) wt_rd_data <= ram[wt_addr];
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (wt_wr_en) ram[wt_addr] <= wt_wr_data;
        if (wt_rd_en) acc_log.push_back(int'(wt_addr));
        if (wt_wr_en) acc_log.push_back(1000 + int'(wt_addr));
        if (upd_done) n_done <= n_done + 1;
    end

    int ref_w [64][20];
    int m_theta, m_tc, exp_trained, exp_skipped;
    int errors, checks;

    function automatic logic [31:0] pack(input int row, input int g);
        logic [31:0] e;
        for (int k = 0; k < 4; k++) e[k*8 +: 8] = 8'(ref_w[row][g*4+k]);
        return e;
    endfunction

    task automatic model_reset();
        m_theta = THETA0; m_tc = 0; exp_trained = 0; exp_skipped = 0;
    endtask

    task automatic model_apply(input int row, input logic [15:0] hist, input bit out, input int upto);
        int x, t, v;
        t = out ? 1 : -1;
        for (int j = 0; j < upto && j <= H; j++) begin
            x = (j == 0) ? 1 : (hist[j-1] ? 1 : -1);
            v = ref_w[row][j] + t * x;
            if (v > 127) v = 127;
            if (v < -128) v = -128;
            ref_w[row][j] = v;
        end
    endtask

    task automatic model_req(input int row, input logic [15:0] hist, input int sum, input bit out);
        int a;
        bit pred, mis;
        pred = (sum >= 0);
        mis  = (pred != out);
        a    = (sum < 0) ? -sum : sum;
        if (mis || a <= m_theta) begin
            exp_trained++;
            model_apply(row, hist, out, H + 1);
`ifdef PERCEPTRON_ADAPTIVE_THETA_EN
            if (mis) begin
                m_tc++;
                if (m_tc == 63) begin m_tc = 0; if (m_theta < 255) m_theta++; end
            end else begin
                m_tc--;
                if (m_tc == -64) begin m_tc = 0; if (m_theta > 1) m_theta--; end
            end
`endif
        end else begin
            exp_skipped++;
        end
    endtask

    task automatic ram_write(input int a, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = 9'(a); pre_data = d;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    task automatic push(input int row, input logic [15:0] hist, input int sum, input bit out);
        int w;
        @(negedge clk);
        req_valid = 1'b1; req_idx = 6'(row); req_hist = hist;
        req_sum = 16'(sum); req_outcome = out;
        w = 0;
        while (!req_ready && w < 400) begin @(negedge clk); w++; end
        checks++;
        if (!req_ready) begin
            errors++;
            $display("FAIL handshake row %0d: req_ready=%b after %0d cycles, required 1", row, req_ready, w);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_req(row, hist, sum, out);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int maxc, input string tag);
        int c;
        c = 0;
        @(negedge clk);
        while (busy && c < maxc) begin @(negedge clk); c++; end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL %s idle timeout: busy=%b after %0d cycles, required 0", tag, busy, c);
        end
    endtask

    task automatic check_counts(input string tag);
        checks++;
        if (trained_cnt !== 32'(exp_trained)) begin
            errors++;
            $display("FAIL %s trained_cnt: got %0d want %0d", tag, trained_cnt, exp_trained);
        end
        checks++;
        if (skipped_cnt !== 32'(exp_skipped)) begin
            errors++;
            $display("FAIL %s skipped_cnt: got %0d want %0d", tag, skipped_cnt, exp_skipped);
        end
    endtask

    task automatic check_ram(input string tag);
        logic [31:0] e;
        for (int row = 0; row < 64; row++)
            for (int g = 0; g < 5; g++) begin
                e = pack(row, g);
                checks++;
                if (ram[row*8+g] !== e) begin
                    errors++;
                    $display("FAIL %s ram row %0d grp %0d: got %h want %h", tag, row, g, ram[row*8+g], e);
                end
            end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req_valid = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; pre_we = 1'b0;
        req_idx = '0; req_hist = '0; req_sum = '0; req_outcome = 1'b0;
        model_reset();
        #12;
        checks++;
        if ({req_ready, busy, upd_done, wt_rd_en, wt_wr_en} !== 5'b0) begin
            errors++;
            $display("FAIL reset flags: got %b want 00000", {req_ready, busy, upd_done, wt_rd_en, wt_wr_en});
        end
        checks++;
        if ({wt_addr, wt_wr_data, trained_cnt, skipped_cnt} !== '0) begin
            errors++;
            $display("FAIL reset buses: addr=%h wdata=%h tr=%0d sk=%0d want all 0", wt_addr, wt_wr_data, trained_cnt, skipped_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset release req_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic preload_all();
        for (int row = 0; row < 64; row++)
            for (int g = 0; g < 5; g++) begin
                for (int k = 0; k < 4; k++) ref_w[row][g*4+k] = int'($urandom_range(0, 255)) - 128;
                ram_write(row*8+g, pack(row, g));
            end
    endtask

    task automatic test_single();
        int base, n;
        logic [31:0] want [5];
        for (int j = 0; j < 20; j++) ref_w[3][j] = 0;
        for (int g = 0; g < 5; g++) ram_write(3*8+g, 32'h0);
        base = acc_log.size();
        push(3, 16'h0001, -100, 1'b1);
        n = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (upd_done) begin n = i; break; end
        end
        checks++;
        if (n != 11) begin errors++; $display("FAIL single latency: got %0d want 11", n); end
        @(posedge clk); #1;
        checks++;
        if (upd_done !== 1'b0) begin errors++; $display("FAIL single upd_done width: got %b want 0", upd_done); end
        checks++;
        if (acc_log.size() != base + 10) begin
            errors++;
            $display("FAIL single access count: got %0d want 10", acc_log.size() - base);
        end else begin
            for (int g = 0; g < 5; g++) begin
                checks++;
                if (acc_log[base+2*g] != 24 + g || acc_log[base+2*g+1] != 1024 + g) begin
                    errors++;
                    $display("FAIL single order grp %0d: got %0d/%0d want %0d/%0d", g,
                             acc_log[base+2*g], acc_log[base+2*g+1], 24 + g, 1024 + g);
                end
            end
        end
        want[0] = 32'hFFFF0101; want[1] = 32'hFFFFFFFF; want[2] = 32'hFFFFFFFF;
        want[3] = 32'hFFFFFFFF; want[4] = 32'h000000FF;
        for (int g = 0; g < 5; g++) begin
            checks++;
            if (ram[24+g] !== want[g]) begin
                errors++;
                $display("FAIL single weights grp %0d: got %h want %h", g, ram[24+g], want[g]);
            end
        end
        check_counts("single");
    endtask

    task automatic test_filter();
        int base, sum, r;
        logic [15:0] h;
        base = acc_log.size();
        push(7, 16'($urandom), 100, 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || acc_log.size() != base) begin
            errors++;
            $display("FAIL filter skip: busy=%b accesses=%0d want 0/0", busy, acc_log.size() - base);
        end
        check_counts("filter_skip");
        push(7, 16'($urandom), 44, 1'b1);
        push(7, 16'($urandom), 45, 1'b1);
        push(8, 16'($urandom), -45, 1'b0);
        push(8, 16'($urandom), -44, 1'b0);
        wait_idle(200, "filter_edge");
        check_counts("filter_edge");
        for (int i = 0; i < 30; i++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) sum = -32768;
            else if (r == 1) sum = 32767;
            else sum = int'($urandom_range(0, 200)) - 100;
            h = 16'($urandom);
            push(int'($urandom_range(0, 15)), h, sum, 1'($urandom));
        end
        wait_idle(600, "filter_rand");
        check_counts("filter_rand");
        check_ram("filter");
    endtask

    task automatic test_saturation();
        ref_w[10][1] = 127;
        ram_write(80, pack(10, 0));
        push(10, 16'h0001, -5, 1'b1);
        wait_idle(100, "sat_hi");
        checks++;
        if (ram[80][15:8] !== 8'h7F) begin errors++; $display("FAIL sat_hi w1: got %h want 7f", ram[80][15:8]); end
        ref_w[10][1] = -128;
        ram_write(80, pack(10, 0));
        push(10, 16'h0001, 5, 1'b0);
        wait_idle(100, "sat_lo");
        checks++;
        if (ram[80][15:8] !== 8'h80) begin errors++; $display("FAIL sat_lo w1: got %h want 80", ram[80][15:8]); end
        check_ram("sat");
    endtask

    task automatic test_back_to_back();
        int rows [6] = '{5, 5, 6, 5, 7, 5};
        int n0;
        bit o;
        n0 = n_done;
        for (int i = 0; i < 6; i++) begin
            o = 1'($urandom);
            push(rows[i], 16'($urandom), o ? -50 : 50, o);
            if (i == 4) begin
                checks++;
                if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b full req_ready: got %b want 0", req_ready); end
            end
        end
        wait_idle(300, "b2b");
        checks++;
        if (n_done - n0 != 6) begin errors++; $display("FAIL b2b upd_done pulses: got %0d want 6", n_done - n0); end
        check_counts("b2b");
        check_ram("b2b");
    endtask

    task automatic test_reset_mid();
        int saved [20];
        int n0;
        bit hit;
        logic [15:0] h;
        h = 16'($urandom);
        for (int j = 0; j < 20; j++) saved[j] = ref_w[20][j];
        push(20, h, -300, 1'b1);
        hit = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (wt_wr_en && wt_addr == 9'(20*8+2)) begin hit = 1'b1; break; end
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL midreset: WR of group 2 not seen, got 0 want 1"); end
        n0 = n_done;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, busy, upd_done, wt_rd_en, wt_wr_en} !== 5'b0 || wt_addr !== '0 ||
            wt_wr_data !== '0 || trained_cnt !== '0 || skipped_cnt !== '0) begin
            errors++;
            $display("FAIL midreset outputs: flags=%b addr=%h tr=%0d want all 0",
                     {req_ready, busy, upd_done, wt_rd_en, wt_wr_en}, wt_addr, trained_cnt);
        end
        for (int j = 0; j < 20; j++) ref_w[20][j] = saved[j];
        model_apply(20, h, 1'b1, 8);
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (n_done != n0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset after release: pulses=%0d busy=%b want 0/0", n_done - n0, busy);
        end
        check_ram("midreset");
        push(21, 16'($urandom), -10, 1'b1);
        wait_idle(100, "postreset");
        check_counts("postreset");
        check_ram("postreset");
    endtask

    task automatic test_theta();
        do_reset();
        for (int i = 0; i < 63; i++)
            push(int'($urandom_range(30, 40)), 16'($urandom), -1000, 1'b1);
        wait_idle(2000, "theta_feed");
        push(30, 16'($urandom), 45, 1'b1);
        push(31, 16'($urandom), 46, 1'b1);
        wait_idle(100, "theta_probe");
        checks++;
`ifdef PERCEPTRON_ADAPTIVE_THETA_EN
        if (trained_cnt !== 32'd64 || skipped_cnt !== 32'd1) begin
            errors++;
            $display("FAIL theta adapt: tr=%0d sk=%0d want 64/1", trained_cnt, skipped_cnt);
        end
`else
        if (trained_cnt !== 32'd63 || skipped_cnt !== 32'd2) begin
            errors++;
            $display("FAIL theta fixed: tr=%0d sk=%0d want 63/2", trained_cnt, skipped_cnt);
        end
`endif
        check_counts("theta");
        check_ram("theta");
    endtask

    initial begin
        errors = 0; checks = 0;
        test_reset();
        preload_all();
        test_single();
        test_filter();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        test_theta();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
